// File: rtl/seq_shift_unit.sv
// Sequenced shifter: shifts the captured operand one bit per clock in logical,
// arithmetic or rotate mode, then presents the result on Y with a done pulse.
module seq_shift_unit #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y
);

    // state | meaning
    // IDLE  | waiting for start; Y holds the last result
    // SHIFT | one 1-bit step per cycle until the counter reaches zero
    // DONE  | Y valid, done pulses for one cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] step;
    logic [AMT_W-1:0] cnt;
    logic             dir_q;
    logic [1:0]       mode_q;

    // mode 11 decodes as logical
    always_comb begin
        step = work;
        unique case (mode_q)
            2'b01: step = dir_q ? {work[WIDTH-1], work[WIDTH-1:1]}
                                : {work[WIDTH-2:0], 1'b0};
            2'b10: step = dir_q ? {work[0], work[WIDTH-1:1]}
                                : {work[WIDTH-2:0], work[WIDTH-1]};
            default: step = dir_q ? {1'b0, work[WIDTH-1:1]}
                                  : {work[WIDTH-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == DONE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            mode_q <= 2'b00;
            Y      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work   <= A;
                        cnt    <= amt;
                        dir_q  <= dir;
                        mode_q <= mode;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        work <= step;
                        cnt  <= cnt - 1'b1;
                    end else begin
                        Y <= work;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: vector table for results and latency,
// plus hand sequences for busy-time start, mid-shift reset and held start.
module tb_seq_shift_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [1:0] amt;
    logic       dir;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic [3:0] Y;

    logic       start2;
    logic [3:0] a2;
    logic [2:0] amt2;
    logic       dir2;
    logic [1:0] mode2;
    logic       busy2;
    logic       done2;
    logic [3:0] y2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(4), .AMT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .amt(amt),
        .dir(dir), .mode(mode), .busy(busy), .done(done), .Y(Y)
    );

    seq_shift_unit #(.WIDTH(4), .AMT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .amt(amt2),
        .dir(dir2), .mode(mode2), .busy(busy2), .done(done2), .Y(y2)
    );

    typedef struct {
        logic [3:0] a;
        logic [1:0] amt;
        logic       dir;
        logic [1:0] mode;
        logic [3:0] y;
        string      nm;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int cyc;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        A = v.a; amt = v.amt; dir = v.dir; mode = v.mode; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; busy_cnt = 0; seen = 1'b0;
        while (cyc <= 20) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({v.nm, "_latency"}, seen ? cyc : 0, v.amt + 2);
        check({v.nm, "_y"}, Y, v.y);
        check({v.nm, "_busy_cycles"}, busy_cnt, v.amt + 2);
        @(negedge clk);
        check({v.nm, "_idle_after"}, {busy, done}, 2'b00);
        check({v.nm, "_y_hold"}, Y, v.y);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int cyc;
        int spacing;

        vecs[0]  = '{4'b1011, 2'd2, 1'b0, 2'b00, 4'b1100, "lsl2"};
        vecs[1]  = '{4'b1011, 2'd1, 1'b1, 2'b01, 4'b1101, "asr1"};
        vecs[2]  = '{4'b1011, 2'd1, 1'b1, 2'b00, 4'b0101, "lsr1"};
        vecs[3]  = '{4'b1001, 2'd3, 1'b0, 2'b10, 4'b1100, "rol3"};
        vecs[4]  = '{4'b1001, 2'd1, 1'b1, 2'b10, 4'b1100, "ror1"};
        vecs[5]  = '{4'b0110, 2'd0, 1'b1, 2'b10, 4'b0110, "amt0"};
        vecs[6]  = '{4'b1000, 2'd3, 1'b1, 2'b00, 4'b0001, "lsr3"};
        vecs[7]  = '{4'b0111, 2'd1, 1'b0, 2'b11, 4'b1110, "mode11_left"};
        vecs[8]  = '{4'b1011, 2'd1, 1'b0, 2'b01, 4'b0110, "asl1"};
        vecs[9]  = '{4'b0110, 2'd3, 1'b1, 2'b01, 4'b0000, "asr3_pos"};
        vecs[10] = '{4'b0001, 2'd3, 1'b1, 2'b10, 4'b0010, "ror3"};

        rst_n = 1'b0; start = 1'b0; A = '0; amt = '0; dir = 1'b0; mode = '0;
        start2 = 1'b0; a2 = '0; amt2 = '0; dir2 = 1'b0; mode2 = '0;
        #12;
        check("reset_y", Y, 4'b0000);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // AMT_W=3 instance: amount larger than the width, arithmetic right
        @(negedge clk);
        a2 = 4'b1000; amt2 = 3'd5; dir2 = 1'b1; mode2 = 2'b01; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (cyc <= 20 && !done2) begin
            @(negedge clk);
            cyc++;
        end
        check("w4a3_asr5_latency", done2 ? cyc : 0, 7);
        check("w4a3_asr5_y", y2, 4'b1111);

        // start pulses and operand changes while busy are ignored
        @(negedge clk);
        A = 4'b1011; amt = 2'd3; dir = 1'b0; mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ign_y_before", Y, 4'b0010);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                done_cnt++;
                check("busy_ign_y", Y, 4'b1000);
            end
            start = busy ? ~start : 1'b0;
            A = 4'($urandom_range(15));
            amt = 2'd0;
            dir = 1'b1;
            mode = 2'b10;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_ign_done_count", done_cnt, 1);

        // reset after one shift step discards the request
        @(negedge clk);
        A = 4'b1011; amt = 2'd3; dir = 1'b0; mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_y", Y, 4'b0000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("midrst_no_activity", done_cnt, 0);
        run_op(vecs[0]);

        // start held high: requests spaced amt+3 apart
        @(negedge clk);
        A = 4'b0011; amt = 2'd1; dir = 1'b0; mode = 2'b00; start = 1'b1;
        done_cnt = 0; first_done = 0; spacing = 0;
        for (int i = 0; i < 30 && done_cnt < 2; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = i;
                else spacing = i - first_done;
                check("held_y", Y, 4'b0110);
            end
        end
        start = 1'b0;
        check("held_done_count", done_cnt, 2);
        check("held_spacing", spacing, 4);
        @(negedge clk);
        @(negedge clk);
        check("held_idle_after", {busy, done}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
